// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings, FSM state type and lane helpers for the MEM stage
//
// Purpose: store/load control encodings, byte-enable constants, the access FSM
//          state type and the misalignment predicate used by mem_access_stage.
// Ports:   none (package).
package mem_stage_pkg;

    // Store size (SControlIn); 2'b11 is reserved and handled as a word.
    localparam logic [1:0] SC_WORD = 2'b00;
    localparam logic [1:0] SC_HALF = 2'b01;
    localparam logic [1:0] SC_BYTE = 2'b10;
    localparam logic [1:0] SC_RSVD = 2'b11;

    // Load type (LControlIn).
    localparam logic [1:0] LC_LW  = 2'b00;
    localparam logic [1:0] LC_LH  = 2'b01;
    localparam logic [1:0] LC_LB  = 2'b10;
    localparam logic [1:0] LC_LBU = 2'b11;

    // Byte-enable patterns, bit i = byte lane i.
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } memState_t;

    // Half accesses need a[0]==0, word accesses need a[1:0]==0; bytes never trap.
    function automatic logic isMisaligned(
        input logic       isWrite,
        input logic [1:0] sCtl,
        input logic [1:0] lCtl,
        input logic [1:0] a
    );
        logic half;
        logic word;
        half = isWrite ? (sCtl == SC_HALF) : (lCtl == LC_LH);
        word = isWrite ? ((sCtl == SC_WORD) || (sCtl == SC_RSVD)) : (lCtl == LC_LW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// rtl/load_align_extend.sv - combinational load lane extraction and sign/zero extension
//
// Purpose: picks the addressed byte/half out of a little-endian read word and
//          extends it to 32 bits according to the load type.
// Ports:
//   RData    in  32  raw word returned by data memory
//   ByteOff  in  2   byte offset of the load address (a[1:0])
//   LControl in  2   load type: LW, LH (sign), LB (sign), LBU (zero)
//   Result   out 32  aligned/extended load value
module load_align_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] RData,
    input  logic [1:0]  ByteOff,
    input  logic [1:0]  LControl,
    output logic [31:0] Result
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = RData[7:0];
        case (ByteOff)
            2'd1:    byteSel = RData[15:8];
            2'd2:    byteSel = RData[23:16];
            2'd3:    byteSel = RData[31:24];
            default: byteSel = RData[7:0];
        endcase
        // a[0] is ignored for halves: forced alignment when not trapping.
        halfSel = ByteOff[1] ? RData[31:16] : RData[15:0];
    end

    always_comb begin
        Result = RData;
        case (LControl)
            LC_LH:   Result = {{16{halfSel[15]}}, halfSel};
            LC_LB:   Result = {{24{byteSel[7]}}, byteSel};
            LC_LBU:  Result = {24'h000000, byteSel};
            default: Result = RData;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access unit with req/ack handshake
//
// Purpose: converts EX/MEM load/store controls into one req/ack transaction,
//          steers store lanes, aligns/extends loads, stalls the pipeline until
//          the access completes and aborts after ACK_TIMEOUT busy cycles.
// Optional feature: MEM_MISALIGN_TRAP_EN (misaligned half/word accesses trap
//          instead of being force-aligned).
// Ports:
//   Clk, Rst_n               clock (rising edge), async active-low reset
//   ALUResultIn, BIn         byte address and store data from EX/MEM
//   MemReadIn, MemWriteIn    load / store request (write wins if both)
//   SControlIn, LControlIn   store size / load type
//   DMemReq/We/Addr/Be/WData data-memory request fields, held until ack
//   DMemRData, DMemAck       read data and one-cycle completion strobe
//   LoadDataOut, LoadValidOut aligned load result and its one-cycle update pulse
//   StallOut                 pipeline hold
//   BusErrOut                sticky ack-timeout flag
//   MisalignOut              one-cycle misalignment trap flag
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] BIn,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  SControlIn,
    input  logic [1:0]  LControlIn,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [3:0]  DMemBe,
    output logic [31:0] DMemWData,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
    output logic [31:0] LoadDataOut,
    output logic        LoadValidOut,
    output logic        StallOut,
    output logic        BusErrOut,
    output logic        MisalignOut
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    memState_t        state;
    memState_t        stateNext;
    logic [CNT_W-1:0] ackCnt;
    logic [CNT_W-1:0] cntNext;
    logic             timeoutHit;

    logic             isWrite;
    logic             access;
    logic             misalign;
    logic [3:0]       storeBe;
    logic [31:0]      storeData;

    // Request context kept for aligning the returned read word.
    logic             reqIsRead;
    logic [1:0]       reqOff;
    logic [1:0]       reqLCtl;
    logic [31:0]      alignedLoad;

    assign isWrite    = MemWriteIn;
    assign access     = MemReadIn | MemWriteIn;
    assign cntNext    = ackCnt + 1'b1;
    assign timeoutHit = (cntNext == CNT_W'(ACK_TIMEOUT));

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = isMisaligned(isWrite, SControlIn, LControlIn, ALUResultIn[1:0]);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            MisalignOut <= 1'b0;
        end else begin
            MisalignOut <= (state == IDLE) && access && misalign;
        end
    end
`else
    assign misalign    = 1'b0;
    assign MisalignOut = 1'b0;
`endif

    // Store lane steering: replicate the datum so any lane selected by Be holds it.
    always_comb begin
        storeBe   = BE_ALL;
        storeData = BIn;
        case (SControlIn)
            SC_BYTE: begin
                storeBe   = BE_BYTE0 << ALUResultIn[1:0];
                storeData = {4{BIn[7:0]}};
            end
            SC_HALF: begin
                storeBe   = ALUResultIn[1] ? BE_HI_HALF : BE_LO_HALF;
                storeData = {2{BIn[15:0]}};
            end
            default: begin
                storeBe   = BE_ALL;
                storeData = BIn;
            end
        endcase
    end

    load_align_extend uLoadAlign (
        .RData    (DMemRData),
        .ByteOff  (reqOff),
        .LControl (reqLCtl),
        .Result   (alignedLoad)
    );

    always_comb begin
        stateNext = state;
        StallOut  = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    StallOut  = 1'b1;
                    stateNext = misalign ? DONE : BUSY;
                end
            end
            BUSY: begin
                StallOut = 1'b1;
                if (DMemAck || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // An aborted access must not keep the pipeline frozen while reset is held.
        if (!Rst_n) begin
            StallOut = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            ackCnt       <= '0;
            DMemReq      <= 1'b0;
            DMemWe       <= 1'b0;
            DMemAddr     <= '0;
            DMemBe       <= '0;
            DMemWData    <= '0;
            LoadDataOut  <= '0;
            LoadValidOut <= 1'b0;
            BusErrOut    <= 1'b0;
            reqIsRead    <= 1'b0;
            reqOff       <= '0;
            reqLCtl      <= '0;
        end else begin
            state        <= stateNext;
            LoadValidOut <= 1'b0;
            case (state)
                IDLE: begin
                    ackCnt <= '0;
                    if (access && !misalign) begin
                        DMemReq   <= 1'b1;
                        DMemWe    <= isWrite;
                        DMemAddr  <= {ALUResultIn[31:2], 2'b00};
                        DMemBe    <= isWrite ? storeBe : BE_ALL;
                        DMemWData <= isWrite ? storeData : 32'h0;
                        reqIsRead <= ~isWrite;
                        reqOff    <= ALUResultIn[1:0];
                        reqLCtl   <= LControlIn;
                    end
                end
                BUSY: begin
                    ackCnt <= cntNext;
                    // An ack arriving on the timeout cycle still completes the access.
                    if (DMemAck) begin
                        DMemReq <= 1'b0;
                        if (reqIsRead) begin
                            LoadDataOut  <= alignedLoad;
                            LoadValidOut <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        DMemReq   <= 1'b0;
                        BusErrOut <= 1'b1;
                    end
                end
                default: begin
                    ackCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    localparam int ACK_TO = 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] ALUResultIn;
    logic [31:0] BIn;
    logic        MemReadIn;
    logic        MemWriteIn;
    logic [1:0]  SControlIn;
    logic [1:0]  LControlIn;
    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [3:0]  DMemBe;
    logic [31:0] DMemWData;
    logic [31:0] DMemRData;
    logic        DMemAck;
    logic [31:0] LoadDataOut;
    logic        LoadValidOut;
    logic        StallOut;
    logic        BusErrOut;
    logic        MisalignOut;

    mem_access_stage #(.ACK_TIMEOUT(ACK_TO)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .ALUResultIn  (ALUResultIn),
        .BIn          (BIn),
        .MemReadIn    (MemReadIn),
        .MemWriteIn   (MemWriteIn),
        .SControlIn   (SControlIn),
        .LControlIn   (LControlIn),
        .DMemReq      (DMemReq),
        .DMemWe       (DMemWe),
        .DMemAddr     (DMemAddr),
        .DMemBe       (DMemBe),
        .DMemWData    (DMemWData),
        .DMemRData    (DMemRData),
        .DMemAck      (DMemAck),
        .LoadDataOut  (LoadDataOut),
        .LoadValidOut (LoadValidOut),
        .StallOut     (StallOut),
        .BusErrOut    (BusErrOut),
        .MisalignOut  (MisalignOut)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nPass   = 0;

    // {we, addr[31:0], be[3:0], wdata[31:0]}
    logic [68:0] expReq[$];
    logic [31:0] expLoad[$];
    logic        prevReq = 1'b0;
    logic        lastMisalign;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic failNote(input string name);
        nChecks++;
        $display("FAIL %s", name);
    endtask

    // Monitor: new request edges and load-valid pulses are matched against the queues.
    always @(negedge Clk) begin : monitor
        logic [68:0] e;
        if (DMemReq && !prevReq) begin
            if (expReq.size() == 0) begin
                failNote($sformatf("unexpected_req addr=0x%08h", DMemAddr));
            end else begin
                e = expReq.pop_front();
                check("req_we",    32'(DMemWe),  32'(e[68]));
                check("req_addr",  DMemAddr,     e[67:36]);
                check("req_be",    32'(DMemBe),  32'(e[35:32]));
                check("req_wdata", DMemWData,    e[31:0]);
            end
        end
        prevReq = DMemReq;
        if (LoadValidOut) begin
            if (expLoad.size() == 0) begin
                failNote($sformatf("unexpected_load_valid data=0x%08h", LoadDataOut));
            end else begin
                check("load_data", LoadDataOut, expLoad.pop_front());
            end
        end
    end

    // ackAfter: BUSY cycle (1-based) in which DMemAck is raised; 0 = never.
    task automatic doAccess(input string name, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] sc, input logic [1:0] lc,
                            input int ackAfter, input logic [31:0] rdata,
                            input int expStall, input int expReqCyc);
        int stall  = 0;
        int reqCyc = 0;
        bit done   = 0;
        @(posedge Clk); #1;
        MemReadIn   = rd;
        MemWriteIn  = wr;
        ALUResultIn = a;
        BIn         = b;
        SControlIn  = sc;
        LControlIn  = lc;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge Clk);
            if (StallOut) stall++;
            if (DMemReq) begin
                reqCyc++;
                DMemAck   = (reqCyc == ackAfter);
                DMemRData = rdata;
            end else begin
                DMemAck = 1'b0;
            end
            if (!StallOut) begin
                done = 1;
                lastMisalign = MisalignOut;
            end
        end
        if (!done) failNote({name, "_stall_release_timeout"});
        check({name, "_stall_cycles"}, 32'(stall),  32'(expStall));
        check({name, "_req_cycles"},   32'(reqCyc), 32'(expReqCyc));
        @(posedge Clk); #1;
        MemReadIn  = 1'b0;
        MemWriteIn = 1'b0;
        DMemAck    = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Rst_n       = 1'b0;
        ALUResultIn = '0;
        BIn         = '0;
        MemReadIn   = 1'b0;
        MemWriteIn  = 1'b0;
        SControlIn  = 2'b00;
        LControlIn  = 2'b00;
        DMemRData   = '0;
        DMemAck     = 1'b0;
        #12;
        check("rst_req",       32'(DMemReq),      32'd0);
        check("rst_we",        32'(DMemWe),       32'd0);
        check("rst_be",        32'(DMemBe),       32'd0);
        check("rst_wdata",     DMemWData,         32'd0);
        check("rst_load_data", LoadDataOut,       32'd0);
        check("rst_load_vld",  32'(LoadValidOut), 32'd0);
        check("rst_buserr",    32'(BusErrOut),    32'd0);
        check("rst_stall",     32'(StallOut),     32'd0);
        check("rst_misalign",  32'(MisalignOut),  32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        // LW, ack in first BUSY cycle: minimum latency.
        expReq.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0});
        expLoad.push_back(32'hDEAD_BEEF);
        doAccess("lw", 1, 0, 32'h100, 32'h0, 2'b00, 2'b00, 1, 32'hDEAD_BEEF, 2, 1);

        // LB / LBU on lane 3.
        expReq.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0});
        expLoad.push_back(32'hFFFF_FF80);
        doAccess("lb", 1, 0, 32'h103, 32'h0, 2'b00, 2'b10, 1, 32'h8012_3456, 2, 1);
        expReq.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0});
        expLoad.push_back(32'h0000_0080);
        doAccess("lbu", 1, 0, 32'h103, 32'h0, 2'b00, 2'b11, 1, 32'h8012_3456, 2, 1);

        // LH upper half, negative.
        expReq.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0});
        expLoad.push_back(32'hFFFF_8001);
        doAccess("lh_hi", 1, 0, 32'h102, 32'h0, 2'b00, 2'b01, 1, 32'h8001_ABCD, 2, 1);

        // LH lower half, positive, ack in third BUSY cycle.
        expReq.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0});
        expLoad.push_back(32'h0000_7FFF);
        doAccess("lh_lo_slow", 1, 0, 32'h100, 32'h0, 2'b00, 2'b01, 3, 32'h1234_7FFF, 4, 3);

        // Stores: byte lane 1, upper half.
        expReq.push_back({1'b1, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB});
        doAccess("sb", 0, 1, 32'h201, 32'h0000_00AB, 2'b10, 2'b00, 1, 32'h0, 2, 1);
        expReq.push_back({1'b1, 32'h0000_0200, 4'b1100, 32'hCDEF_CDEF});
        doAccess("sh", 0, 1, 32'h202, 32'h1234_CDEF, 2'b01, 2'b00, 1, 32'h0, 2, 1);

        // Read and write both set: write wins, no load result.
        expReq.push_back({1'b1, 32'h0000_0300, 4'b1111, 32'h1234_5678});
        doAccess("rw_both", 1, 1, 32'h300, 32'h1234_5678, 2'b00, 2'b00, 1, 32'h5555_5555, 2, 1);

`ifdef MEM_MISALIGN_TRAP_EN
        doAccess("lw_misal", 1, 0, 32'h102, 32'h0, 2'b00, 2'b00, 1, 32'h1122_3344, 1, 0);
        check("misalign_flag", 32'(lastMisalign), 32'd1);
        check("misal_load_kept", LoadDataOut, 32'h0000_7FFF);
`else
        expReq.push_back({1'b0, 32'h0000_0100, 4'b1111, 32'h0});
        expLoad.push_back(32'h1122_3344);
        doAccess("lw_misal", 1, 0, 32'h102, 32'h0, 2'b00, 2'b00, 1, 32'h1122_3344, 2, 1);
        check("misalign_flag", 32'(lastMisalign), 32'd0);
`endif

        check("buserr_before_timeout", 32'(BusErrOut), 32'd0);

        // No ack: abort after ACK_TO busy cycles.
        expReq.push_back({1'b1, 32'h0000_0400, 4'b1111, 32'h0000_0005});
        doAccess("timeout", 0, 1, 32'h400, 32'h5, 2'b00, 2'b00, 0, 32'h0, 1 + ACK_TO, ACK_TO);
        check("buserr_set", 32'(BusErrOut), 32'd1);

        expReq.push_back({1'b0, 32'h0000_0104, 4'b1111, 32'h0});
        expLoad.push_back(32'hCAFE_F00D);
        doAccess("lw_after_err", 1, 0, 32'h104, 32'h0, 2'b00, 2'b00, 1, 32'hCAFE_F00D, 2, 1);
        check("buserr_sticky", 32'(BusErrOut), 32'd1);

        // Reset in the middle of BUSY, then a late ack.
        @(posedge Clk); #1;
        expReq.push_back({1'b0, 32'h0000_0500, 4'b1111, 32'h0});
        MemReadIn   = 1'b1;
        ALUResultIn = 32'h500;
        LControlIn  = 2'b00;
        repeat (3) @(negedge Clk);
        check("busy_before_reset", 32'(DMemReq), 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        check("reset_drops_req",   32'(DMemReq),   32'd0);
        check("reset_drops_stall", 32'(StallOut),  32'd0);
        check("reset_clears_err",  32'(BusErrOut), 32'd0);
        @(posedge Clk); #1;
        MemReadIn = 1'b0;
        Rst_n     = 1'b1;
        @(negedge Clk);
        DMemAck   = 1'b1;
        DMemRData = 32'h7777_7777;
        @(negedge Clk);
        DMemAck = 1'b0;
        repeat (3) @(negedge Clk);
        check("late_ack_no_data", LoadDataOut,    32'h0);
        check("late_ack_no_stall", 32'(StallOut), 32'd0);

        check("req_queue_drained",  32'(expReq.size()),  32'd0);
        check("load_queue_drained", 32'(expLoad.size()), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
